// File: rtl/cpu_pkg.sv
// rtl/cpu_pkg.sv - shared CPU widths and writeback entry type
package cpu_pkg;

    localparam int DATA_W = 8;
    localparam int ADDR_W = 2;

    typedef logic [ADDR_W-1:0] reg_id_t;

    // Destination register id plus the value to be written there.
    typedef struct packed {
        reg_id_t             wreg;
        logic [DATA_W-1:0]   data;
    } wb_entry_t;

endpackage

// File: rtl/wb_fifo.sv
// rtl/wb_fifo.sv - circular FIFO of writeback entries with full visibility of its contents
module wb_fifo
    import cpu_pkg::*;
#(
    parameter int  DEPTH = 4,
    localparam int IDX_W = $clog2(DEPTH),
    localparam int CNT_W = IDX_W + 1
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             push,
    input  logic             pop,
    input  wb_entry_t        push_entry,
    output logic [CNT_W-1:0] count,
    output logic [IDX_W-1:0] head,
    output wb_entry_t        entries [DEPTH],
    output logic [DEPTH-1:0] valid
);

    logic [IDX_W-1:0] head_q, head_d;
    logic [IDX_W-1:0] tail_q, tail_d;
    logic [CNT_W-1:0] count_q, count_d;
    wb_entry_t        mem_q [DEPTH];
    wb_entry_t        mem_d [DEPTH];
    logic [IDX_W-1:0] offset;

    // The caller only pushes when not full and only pops when not empty.
    always_comb begin
        head_d  = head_q;
        tail_d  = tail_q;
        count_d = count_q;
        mem_d   = mem_q;
        if (push) begin
            mem_d[tail_q] = push_entry;
            tail_d        = tail_q + IDX_W'(1);
        end
        if (pop) begin
            head_d = head_q + IDX_W'(1);
        end
        case ({push, pop})
            2'b10:   count_d = count_q + CNT_W'(1);
            2'b01:   count_d = count_q - CNT_W'(1);
            default: count_d = count_q;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            head_q  <= '0;
            tail_q  <= '0;
            count_q <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                mem_q[i] <= '0;
            end
        end else begin
            head_q  <= head_d;
            tail_q  <= tail_d;
            count_q <= count_d;
            mem_q   <= mem_d;
        end
    end

    // A slot is live when its distance from head (mod DEPTH) is below count.
    always_comb begin
        valid  = '0;
        offset = '0;
        for (int i = 0; i < DEPTH; i++) begin
            offset   = IDX_W'(i) - head_q;
            valid[i] = ({1'b0, offset} < count_q);
        end
    end

    assign count   = count_q;
    assign head    = head_q;
    assign entries = mem_q;

endmodule

// File: rtl/writeback_queue.sv
// rtl/writeback_queue.sv - buffered register-file write port with pending mask and forwarding
module writeback_queue #(
    parameter int  DEPTH  = 4,
    parameter int  DATA_W = cpu_pkg::DATA_W,
    parameter int  ADDR_W = cpu_pkg::ADDR_W,
    localparam int NREG   = 2 ** ADDR_W,
    localparam int IDX_W  = $clog2(DEPTH),
    localparam int CNT_W  = IDX_W + 1
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [ADDR_W-1:0] in_reg,
    input  logic [DATA_W-1:0] in_data,
    input  logic              hold,
    output logic              write,
    output logic [ADDR_W-1:0] write_reg,
    output logic [DATA_W-1:0] write_data,
    output logic [NREG-1:0]   pending,
    input  logic [ADDR_W-1:0] fwd_reg1,
    input  logic [ADDR_W-1:0] fwd_reg2,
    output logic              fwd_hit1,
    output logic              fwd_hit2,
    output logic [DATA_W-1:0] fwd_data1,
    output logic [DATA_W-1:0] fwd_data2
);

    logic                 push;
    logic                 pop;
    cpu_pkg::wb_entry_t   push_entry;
    logic [CNT_W-1:0]     count;
    logic [IDX_W-1:0]     head;
    cpu_pkg::wb_entry_t   entries [DEPTH];
    logic [DEPTH-1:0]     valid;

    logic                 write_q, write_d;
    logic [ADDR_W-1:0]    write_reg_q, write_reg_d;
    logic [DATA_W-1:0]    write_data_q, write_data_d;

    // No pass-through on full: in_ready depends only on registered count.
    assign in_ready   = (count < CNT_W'(DEPTH));
    assign push       = in_valid && in_ready;
    assign pop        = (count != '0) && !hold;
    assign push_entry = '{wreg: in_reg, data: in_data};

    wb_fifo #(.DEPTH(DEPTH)) u_fifo (
        .clk        (clk),
        .reset      (reset),
        .push       (push),
        .pop        (pop),
        .push_entry (push_entry),
        .count      (count),
        .head       (head),
        .entries    (entries),
        .valid      (valid)
    );

    always_comb begin
        write_d      = pop;
        write_reg_d  = write_reg_q;
        write_data_d = write_data_q;
        if (pop) begin
            write_reg_d  = entries[head].wreg;
            write_data_d = entries[head].data;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            write_q      <= 1'b0;
            write_reg_q  <= '0;
            write_data_q <= '0;
        end else begin
            write_q      <= write_d;
            write_reg_q  <= write_reg_d;
            write_data_q <= write_data_d;
        end
    end

    assign write      = write_q;
    assign write_reg  = write_reg_q;
    assign write_data = write_data_q;

    always_comb begin
        pending = '0;
        for (int k = 0; k < DEPTH; k++) begin
            if (valid[k]) begin
                pending[entries[k].wreg] = 1'b1;
            end
        end
        if (write_q) begin
            pending[write_reg_q] = 1'b1;
        end
    end

    logic [ADDR_W-1:0] lk_reg  [2];
    logic              lk_hit  [2];
    logic [DATA_W-1:0] lk_data [2];
    logic [IDX_W-1:0]  lk_idx;

    assign lk_reg[0] = fwd_reg1;
    assign lk_reg[1] = fwd_reg2;

    // Scan oldest to youngest so the last match wins: output stage first,
    // then queue entries from head towards tail.
    always_comb begin
        lk_idx = '0;
        for (int p = 0; p < 2; p++) begin
            lk_hit[p]  = 1'b0;
            lk_data[p] = '0;
            if (write_q && (write_reg_q == lk_reg[p])) begin
                lk_hit[p]  = 1'b1;
                lk_data[p] = write_data_q;
            end
            for (int k = 0; k < DEPTH; k++) begin
                lk_idx = head + IDX_W'(k);
                if ((CNT_W'(k) < count) && (entries[lk_idx].wreg == lk_reg[p])) begin
                    lk_hit[p]  = 1'b1;
                    lk_data[p] = entries[lk_idx].data;
                end
            end
        end
    end

    assign fwd_hit1  = lk_hit[0];
    assign fwd_data1 = lk_data[0];
    assign fwd_hit2  = lk_hit[1];
    assign fwd_data2 = lk_data[1];

endmodule

// File: tb/tb_writeback_queue.sv
// tb/tb_writeback_queue.sv - self-checking bench for writeback_queue
module tb_writeback_queue;

    localparam int DEPTH  = 4;
    localparam int DATA_W = 8;
    localparam int ADDR_W = 2;
    localparam int NREG   = 4;

    logic              clk = 1'b0;
    logic              reset;
    logic              in_valid;
    logic              in_ready;
    logic [ADDR_W-1:0] in_reg;
    logic [DATA_W-1:0] in_data;
    logic              hold;
    logic              write;
    logic [ADDR_W-1:0] write_reg;
    logic [DATA_W-1:0] write_data;
    logic [NREG-1:0]   pending;
    logic [ADDR_W-1:0] fwd_reg1, fwd_reg2;
    logic              fwd_hit1, fwd_hit2;
    logic [DATA_W-1:0] fwd_data1, fwd_data2;

    always #5 clk = ~clk;

    writeback_queue #(.DEPTH(DEPTH), .DATA_W(DATA_W), .ADDR_W(ADDR_W)) dut (
        .clk        (clk),
        .reset      (reset),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .in_reg     (in_reg),
        .in_data    (in_data),
        .hold       (hold),
        .write      (write),
        .write_reg  (write_reg),
        .write_data (write_data),
        .pending    (pending),
        .fwd_reg1   (fwd_reg1),
        .fwd_reg2   (fwd_reg2),
        .fwd_hit1   (fwd_hit1),
        .fwd_hit2   (fwd_hit2),
        .fwd_data1  (fwd_data1),
        .fwd_data2  (fwd_data2)
    );

    int checks = 0;
    int errors = 0;

    typedef struct packed {
        logic [1:0] r;
        logic [7:0] d;
    } ent_t;

    // Reference: a plain list of queued writes plus the last popped one.
    ent_t mq[$];
    logic m_write;
    ent_t m_out;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    function automatic logic [3:0] m_pending();
        logic [3:0] p;
        p = '0;
        foreach (mq[i]) p[mq[i].r] = 1'b1;
        if (m_write) p[m_out.r] = 1'b1;
        return p;
    endfunction

    function automatic logic [8:0] m_fwd(input logic [1:0] r);
        for (int i = mq.size() - 1; i >= 0; i--) begin
            if (mq[i].r == r) return {1'b1, mq[i].d};
        end
        if (m_write && m_out.r == r) return {1'b1, m_out.d};
        return 9'h000;
    endfunction

    task automatic model_reset();
        mq.delete();
        m_write = 1'b0;
        m_out   = '0;
    endtask

    task automatic model_edge();
        bit pu, po;
        pu = in_valid && (mq.size() < DEPTH);
        po = (mq.size() > 0) && !hold;
        if (po) begin
            m_out   = mq.pop_front();
            m_write = 1'b1;
        end else begin
            m_write = 1'b0;
        end
        if (pu) mq.push_back({in_reg, in_data});
    endtask

    task automatic check_model(input string tag);
        logic [8:0] f1, f2;
        f1 = m_fwd(fwd_reg1);
        f2 = m_fwd(fwd_reg2);
        chk({tag, " in_ready"},   32'(in_ready),   32'(mq.size() < DEPTH));
        chk({tag, " write"},      32'(write),      32'(m_write));
        chk({tag, " write_reg"},  32'(write_reg),  32'(m_out.r));
        chk({tag, " write_data"}, 32'(write_data), 32'(m_out.d));
        chk({tag, " pending"},    32'(pending),    32'(m_pending()));
        chk({tag, " fwd_hit1"},   32'(fwd_hit1),   32'(f1[8]));
        chk({tag, " fwd_data1"},  32'(fwd_data1),  32'(f1[7:0]));
        chk({tag, " fwd_hit2"},   32'(fwd_hit2),   32'(f2[8]));
        chk({tag, " fwd_data2"},  32'(fwd_data2),  32'(f2[7:0]));
    endtask

    task automatic drive(input logic v, input logic [1:0] r, input logic [7:0] d,
                         input logic h, input logic [1:0] f1, input logic [1:0] f2);
        @(negedge clk);
        in_valid = v;
        in_reg   = r;
        in_data  = d;
        hold     = h;
        fwd_reg1 = f1;
        fwd_reg2 = f2;
        #1;
    endtask

    task automatic tick();
        @(posedge clk);
        model_edge();
    endtask

    typedef struct {
        logic       v;
        logic [1:0] r;
        logic [7:0] d;
        logic       h;
        logic [1:0] f1;
        logic [1:0] f2;
        logic       e_ready;
        logic       e_write;
        logic [1:0] e_wreg;
        logic [7:0] e_wdata;
        logic [3:0] e_pend;
        logic       e_hit1;
        logic [7:0] e_d1;
        logic       e_hit2;
        logic [7:0] e_d2;
    } vec_t;

    vec_t vecs[12];
    logic [7:0] drain_d[4];
    logic [1:0] drain_r[4];

    initial begin
        vecs[0]  = '{1'b0, 2'd0, 8'h00, 1'b1, 2'd1, 2'd0, 1'b1, 1'b0, 2'd0, 8'h00, 4'b0000, 1'b0, 8'h00, 1'b0, 8'h00};
        vecs[1]  = '{1'b1, 2'd1, 8'h5A, 1'b0, 2'd1, 2'd0, 1'b1, 1'b0, 2'd0, 8'h00, 4'b0000, 1'b0, 8'h00, 1'b0, 8'h00};
        vecs[2]  = '{1'b0, 2'd0, 8'h00, 1'b0, 2'd1, 2'd0, 1'b1, 1'b0, 2'd0, 8'h00, 4'b0010, 1'b1, 8'h5A, 1'b0, 8'h00};
        vecs[3]  = '{1'b0, 2'd0, 8'h00, 1'b0, 2'd1, 2'd0, 1'b1, 1'b1, 2'd1, 8'h5A, 4'b0010, 1'b1, 8'h5A, 1'b0, 8'h00};
        vecs[4]  = '{1'b0, 2'd0, 8'h00, 1'b1, 2'd1, 2'd0, 1'b1, 1'b0, 2'd1, 8'h5A, 4'b0000, 1'b0, 8'h00, 1'b0, 8'h00};
        vecs[5]  = '{1'b1, 2'd3, 8'h10, 1'b1, 2'd3, 2'd0, 1'b1, 1'b0, 2'd1, 8'h5A, 4'b0000, 1'b0, 8'h00, 1'b0, 8'h00};
        vecs[6]  = '{1'b1, 2'd3, 8'h20, 1'b1, 2'd3, 2'd3, 1'b1, 1'b0, 2'd1, 8'h5A, 4'b1000, 1'b1, 8'h10, 1'b1, 8'h10};
        vecs[7]  = '{1'b0, 2'd0, 8'h00, 1'b0, 2'd3, 2'd0, 1'b1, 1'b0, 2'd1, 8'h5A, 4'b1000, 1'b1, 8'h20, 1'b0, 8'h00};
        vecs[8]  = '{1'b0, 2'd0, 8'h00, 1'b1, 2'd3, 2'd0, 1'b1, 1'b1, 2'd3, 8'h10, 4'b1000, 1'b1, 8'h20, 1'b0, 8'h00};
        vecs[9]  = '{1'b0, 2'd0, 8'h00, 1'b0, 2'd3, 2'd0, 1'b1, 1'b0, 2'd3, 8'h10, 4'b1000, 1'b1, 8'h20, 1'b0, 8'h00};
        vecs[10] = '{1'b0, 2'd0, 8'h00, 1'b1, 2'd3, 2'd0, 1'b1, 1'b1, 2'd3, 8'h20, 4'b1000, 1'b1, 8'h20, 1'b0, 8'h00};
        vecs[11] = '{1'b0, 2'd0, 8'h00, 1'b1, 2'd3, 2'd0, 1'b1, 1'b0, 2'd3, 8'h20, 4'b0000, 1'b0, 8'h00, 1'b0, 8'h00};

        drain_d = '{8'h22, 8'h33, 8'h44, 8'h55};
        drain_r = '{2'd2, 2'd2, 2'd2, 2'd1};

        reset    = 1'b1;
        in_valid = 1'b0;
        in_reg   = '0;
        in_data  = '0;
        hold     = 1'b1;
        fwd_reg1 = '0;
        fwd_reg2 = '0;
        model_reset();
        repeat (2) @(posedge clk);
        @(negedge clk);
        reset = 1'b0;

        // Directed vectors: single write latency, duplicate-register forwarding.
        for (int i = 0; i < 12; i++) begin
            drive(vecs[i].v, vecs[i].r, vecs[i].d, vecs[i].h, vecs[i].f1, vecs[i].f2);
            chk($sformatf("vec%0d in_ready", i),   32'(in_ready),   32'(vecs[i].e_ready));
            chk($sformatf("vec%0d write", i),      32'(write),      32'(vecs[i].e_write));
            chk($sformatf("vec%0d write_reg", i),  32'(write_reg),  32'(vecs[i].e_wreg));
            chk($sformatf("vec%0d write_data", i), 32'(write_data), 32'(vecs[i].e_wdata));
            chk($sformatf("vec%0d pending", i),    32'(pending),    32'(vecs[i].e_pend));
            chk($sformatf("vec%0d fwd_hit1", i),   32'(fwd_hit1),   32'(vecs[i].e_hit1));
            chk($sformatf("vec%0d fwd_data1", i),  32'(fwd_data1),  32'(vecs[i].e_d1));
            chk($sformatf("vec%0d fwd_hit2", i),   32'(fwd_hit2),   32'(vecs[i].e_hit2));
            chk($sformatf("vec%0d fwd_data2", i),  32'(fwd_data2),  32'(vecs[i].e_d2));
            tick();
        end

        // Fill to full under hold, then push while popping: push must be rejected.
        for (int i = 0; i < 4; i++) begin
            drive(1'b1, 2'd2, 8'((i + 1) * 8'h11), 1'b1, 2'd2, 2'd0);
            chk($sformatf("fill%0d in_ready", i), 32'(in_ready), 32'd1);
            tick();
        end
        drive(1'b1, 2'd1, 8'h55, 1'b0, 2'd2, 2'd1);
        chk("full in_ready", 32'(in_ready), 32'd0);
        chk("full pending", 32'(pending), 32'b0100);
        chk("full fwd_data1", 32'(fwd_data1), 32'h44);
        tick();
        drive(1'b1, 2'd1, 8'h55, 1'b0, 2'd2, 2'd1);
        chk("reaccept in_ready", 32'(in_ready), 32'd1);
        chk("reaccept write", 32'(write), 32'd1);
        chk("reaccept write_data", 32'(write_data), 32'h11);
        tick();
        for (int j = 0; j < 4; j++) begin
            drive(1'b0, 2'd0, 8'h00, 1'b0, 2'd1, 2'd2);
            chk($sformatf("drain%0d write", j), 32'(write), 32'd1);
            chk($sformatf("drain%0d write_reg", j), 32'(write_reg), 32'(drain_r[j]));
            chk($sformatf("drain%0d write_data", j), 32'(write_data), 32'(drain_d[j]));
            check_model($sformatf("drain%0d", j));
            tick();
        end
        drive(1'b0, 2'd0, 8'h00, 1'b1, 2'd1, 2'd2);
        chk("drained write", 32'(write), 32'd0);
        chk("drained pending", 32'(pending), 32'd0);
        tick();

        // Asynchronous reset mid-cycle while strobing with three entries queued.
        for (int i = 0; i < 4; i++) begin
            drive(1'b1, 2'(i), 8'(8'hA1 + i), 1'b1, 2'd0, 2'd0);
            tick();
        end
        drive(1'b0, 2'd0, 8'h00, 1'b0, 2'd0, 2'd0);
        tick();
        drive(1'b0, 2'd0, 8'h00, 1'b1, 2'd2, 2'd3);
        chk("pre_reset write", 32'(write), 32'd1);
        chk("pre_reset write_data", 32'(write_data), 32'hA1);
        chk("pre_reset pending", 32'(pending), 32'b1111);
        #2;
        reset = 1'b1;
        #1;
        chk("async_reset write", 32'(write), 32'd0);
        chk("async_reset write_reg", 32'(write_reg), 32'd0);
        chk("async_reset write_data", 32'(write_data), 32'd0);
        chk("async_reset in_ready", 32'(in_ready), 32'd1);
        chk("async_reset pending", 32'(pending), 32'd0);
        chk("async_reset fwd_hit1", 32'(fwd_hit1), 32'd0);
        chk("async_reset fwd_data1", 32'(fwd_data1), 32'd0);
        chk("async_reset fwd_hit2", 32'(fwd_hit2), 32'd0);
        model_reset();
        @(posedge clk);
        @(negedge clk);
        reset = 1'b0;
        for (int i = 0; i < 4; i++) begin
            drive(1'b0, 2'd0, 8'h00, 1'b0, 2'd2, 2'd3);
            chk($sformatf("post_reset%0d write", i), 32'(write), 32'd0);
            check_model($sformatf("post_reset%0d", i));
            tick();
        end

        // Random traffic against the reference model.
        for (int n = 0; n < 400; n++) begin
            drive(1'($urandom_range(0, 9) < 6), 2'($urandom_range(0, 3)), 8'($urandom_range(0, 255)),
                  1'($urandom_range(0, 3) == 0), 2'($urandom_range(0, 3)), 2'($urandom_range(0, 3)));
            check_model($sformatf("rand%0d", n));
            tick();
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
